serdes_secded_link: RTL

// - Parametrised successor to the fixed-configuration ECC serdes.
// - Accepts parallel words through a valid/ready FIFO. Optionally SECDED-encodes each word, serialises it LSB-first

---
 rtl/serdes_secded_link.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/serdes_secded_link.sv
// serdes_secded_link: FIFO-fed SECDED serialiser/deserialiser loop over a 1-bit lane.
// Ports: clk_i/rst_i (async high); parallel_in_i/valid_in_i/ready_out_o push side;
//   inject_en_i/inject_mask_i per-word codeword error injection;
//   parallel_out_o/valid_out_o/err_corrected_o/err_uncorrectable_o output strobe;
//   corr_cnt_o/uncorr_cnt_o saturating counters; fifo_full_o/fifo_empty_o status.
module serdes_secded_link #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ECC_EN     = 1,
  parameter int CNT_WIDTH  = 16,
  localparam int P  = (ECC_EN == 0)       ? 0 :
                      (DATA_WIDTH <= 4)   ? 3 :
                      (DATA_WIDTH <= 11)  ? 4 :
                      (DATA_WIDTH <= 26)  ? 5 :
                      (DATA_WIDTH <= 57)  ? 6 :
                      (DATA_WIDTH <= 120) ? 7 : 8,
  localparam int CW = (ECC_EN != 0) ? DATA_WIDTH + P + 1 : DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] parallel_in_i,
  input  logic                  valid_in_i,
  output logic                  ready_out_o,
  input  logic                  inject_en_i,
  input  logic [CW-1:0]         inject_mask_i,
  output logic [DATA_WIDTH-1:0] parallel_out_o,
  output logic                  valid_out_o,
  output logic                  err_corrected_o,
  output logic                  err_uncorrectable_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
  output logic                  fifo_full_o,
  output logic                  fifo_empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = CW + DATA_WIDTH;
  localparam int BW = $clog2(CW);
  localparam logic [BW-1:0] LAST   = BW'(CW - 1);
  localparam logic [AW:0]   FULL_N = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  // Data bits fill the non-power-of-two positions in ascending order.
  function automatic logic [CW-1:0] secded_enc(
    input logic [DATA_WIDTH-1:0] d
  );
    logic [CW-1:0] c;
    logic          x;
    int            j;
    c = '0;
    j = 0;
    for (int i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int b = 0; b < P; b++) begin
      x = 1'b0;
      for (int i = 1; i < CW; i++)
        if (((i >> b) & 1) == 1) x = x ^ c[i];
      c[1 << b] = x;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cw_data(
    input logic [CW-1:0] c
  );
    logic [DATA_WIDTH-1:0] d;
    int                    j;
    d = '0;
    j = 0;
    for (int i = 1; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  // ---------------- input FIFO ----------------
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, empty, push, pop;
  logic [CW-1:0] mask_in;
  logic [EW-1:0] head;

  assign full    = (cnt_q == FULL_N);
  assign empty   = (cnt_q == '0);
  assign push    = valid_in_i && !full;
  assign mask_in = inject_en_i ? inject_mask_i : '0;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {mask_in, parallel_in_i};
  end

  // ---------------- encode / decode ----------------
  logic [CW-1:0]         enc;
  logic [CW-1:0]         rx_q, rx_d;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_corr, dec_uncorr;

  if (ECC_EN != 0) begin : g_ecc
    logic [P-1:0]  syn;
    logic          par;
    logic [CW-1:0] fixed;
    assign enc = secded_enc(head[DATA_WIDTH-1:0]);
    always_comb begin
      syn = '0;
      for (int i = 1; i < CW; i++)
        if (rx_q[i]) syn = syn ^ P'(i);
      par   = ^rx_q;
      fixed = rx_q;
      // Odd parity: single error at position syn (0 = parity bit).
      if (par && (int'(syn) < CW)) fixed[syn] = ~fixed[syn];
      dec_data   = cw_data(par ? fixed : rx_q);
      dec_corr   = par;
      dec_uncorr = !par && (syn != '0);
    end
  end else begin : g_raw
    assign enc        = head[DATA_WIDTH-1:0];
    assign dec_data   = rx_q;
    assign dec_corr   = 1'b0;
    assign dec_uncorr = 1'b0;
  end

  // ---------------- serialiser ----------------
  state_e        state_q, state_d;
  logic [CW-1:0] sh_q, sh_d;
  logic [BW-1:0] scnt_q, scnt_d;
  logic          lane_bit, lane_vld;

  assign lane_bit = sh_q[0];
  assign lane_vld = (state_q == S_SHIFT);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scnt_d  = scnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = enc ^ head[EW-1:DATA_WIDTH];
          scnt_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_d   = sh_q >> 1;
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == LAST) begin
          scnt_d = '0;
          if (!empty) begin
            pop  = 1'b1;
            sh_d = enc ^ head[EW-1:DATA_WIDTH];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- deserialiser / output ----------------
  logic [BW-1:0]         rcnt_q, rcnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vout_q, vout_d;
  logic                  corr_q, corr_d;
  logic                  unc_q, unc_d;
  logic [CNT_WIDTH-1:0]  ccnt_q, ccnt_d;
  logic [CNT_WIDTH-1:0]  ucnt_q, ucnt_d;

  always_comb begin
    rx_d   = rx_q;
    rcnt_d = rcnt_q;
    done_d = 1'b0;
    if (lane_vld) begin
      rx_d = {lane_bit, rx_q[CW-1:1]};
      if (rcnt_q == LAST) begin
        rcnt_d = '0;
        done_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
    vout_d = done_q;
    dout_d = done_q ? dec_data : dout_q;
    corr_d = done_q && dec_corr;
    unc_d  = done_q && dec_uncorr;
    ccnt_d = ccnt_q;
    ucnt_d = ucnt_q;
    if (corr_d && (ccnt_q != '1)) ccnt_d = ccnt_q + 1'b1;
    if (unc_d && (ucnt_q != '1))  ucnt_d = ucnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      sh_q     <= '0;
      scnt_q   <= '0;
      rx_q     <= '0;
      rcnt_q   <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      corr_q   <= 1'b0;
      unc_q    <= 1'b0;
      ccnt_q   <= '0;
      ucnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      sh_q     <= sh_d;
      scnt_q   <= scnt_d;
      rx_q     <= rx_d;
      rcnt_q   <= rcnt_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      corr_q   <= corr_d;
      unc_q    <= unc_d;
      ccnt_q   <= ccnt_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign ready_out_o         = !full;
  assign fifo_full_o         = full;
  assign fifo_empty_o        = empty;
  assign parallel_out_o      = dout_q;
  assign valid_out_o         = vout_q;
  assign err_corrected_o     = corr_q;
  assign err_uncorrectable_o = unc_q;
  assign corr_cnt_o          = ccnt_q;
  assign uncorr_cnt_o        = ucnt_q;

endmodule
